// File: rtl/full_stage_seq.sv
// full_stage_seq: loads the tap memory once, then double-buffers input
// vectors and replays each buffered vector P times to the MAC lanes, with
// forward or transposed (error) tap addressing chosen per vector.

// One vector buffer bank: N_IN words, a full flag and the vector's mode.
module full_stage_seq_bank #(
  parameter int N_IN = 8,
  parameter int DW   = 32,
  parameter int IW   = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [IW-1:0] wr_idx,
  input  logic [DW-1:0] wr_data,
  input  logic          mode_we,
  input  logic          mode_in,
  input  logic          set_full,
  input  logic          clr_full,
  input  logic [IW-1:0] rd_idx,
  output logic [DW-1:0] rd_data,
  output logic          full,
  output logic          mode
);

  logic [N_IN-1:0][DW-1:0] mem;

  // Vector words; contents are don't-care until the bank is marked full.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_data;
  end

  // Full flag and per-vector mode. Set and clear never coincide on one
  // bank: set needs !full (fill side), clear needs full (drain side).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full <= 1'b0;
      mode <= 1'b0;
    end else begin
      if (set_full)      full <= 1'b1;
      else if (clr_full) full <= 1'b0;
      if (mode_we) mode <= mode_in;
    end
  end

  assign rd_data = mem[rd_idx];

endmodule

module full_stage_seq #(
  parameter int N_IN  = 8,
  parameter int N_OUT = 6,
  parameter int LANES = 2,
  parameter int DW    = 32,
  localparam int P  = N_OUT / LANES,
  localparam int NT = N_IN * N_OUT,
  localparam int TW = (NT > 1) ? $clog2(NT) : 1,
  localparam int RW = ((NT / LANES) > 1) ? $clog2(NT / LANES) : 1,
  localparam int IW = $clog2(N_IN),
  localparam int PW = (P > 1) ? $clog2(P) : 1
) (
  input  logic          clk,
  input  logic          reset,
  // tap load
  input  logic [DW-1:0] tap_in,
  input  logic          tap_in_vld,
  output logic          tap_in_rdy,
  output logic          tap_wr_en,
  output logic [TW-1:0] tap_wr_addr,
  output logic [DW-1:0] tap_wr_data,
  output logic          load_finish,
  // input vector stream
  input  logic [DW-1:0] stage_data,
  input  logic          stage_data_vld,
  input  logic          stage_data_fst,
  output logic          stage_data_rdy,
  input  logic          mode,
  // operand stream to MAC lanes
  output logic [DW-1:0] op_data,
  output logic [RW-1:0] op_tap_addr,
  output logic          op_vld,
  input  logic          op_rdy,
  output logic          op_first,
  output logic          op_last,
  output logic          op_mode,
  output logic          fst_err
);

  // ---------------------------------------------------------------- tap load
  typedef enum logic {S_LOAD, S_RUN} ld_state_t;

  ld_state_t     ld_state, ld_state_nxt;
  logic [TW-1:0] k, k_nxt;

  // Tap loader state and write counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ld_state <= S_LOAD;
      k        <= '0;
    end else begin
      ld_state <= ld_state_nxt;
      k        <= k_nxt;
    end
  end

  // Taps stream straight through to the tap memory; the last one flips
  // to RUN so load_finish comes up registered on the following cycle.
  always_comb begin
    ld_state_nxt = ld_state;
    k_nxt        = k;
    tap_in_rdy   = 1'b0;
    tap_wr_en    = 1'b0;
    load_finish  = 1'b0;
    case (ld_state)
      S_LOAD: begin
        tap_in_rdy = 1'b1;
        tap_wr_en  = tap_in_vld;
        if (tap_in_vld) begin
          if (k == TW'(NT - 1)) begin
            k_nxt        = '0;
            ld_state_nxt = S_RUN;
          end else begin
            k_nxt = k + TW'(1);
          end
        end
      end
      S_RUN:   load_finish = 1'b1;
      default: ld_state_nxt = S_LOAD;
    endcase
  end

  assign tap_wr_addr = k;
  assign tap_wr_data = tap_in;

  // -------------------------------------------------------------- fill side
  logic                wb, rb;
  logic [IW-1:0]       wi;
  logic [1:0]          full, bmode;
  logic [1:0][DW-1:0]  rd_data;
  logic                fill_acc, resync, wr_last;
  logic [IW-1:0]       wr_idx;

  assign stage_data_rdy = load_finish && !full[wb];
  assign fill_acc       = stage_data_vld && stage_data_rdy;
  // fst mid-vector restarts the vector: that word becomes word 0.
  assign resync         = stage_data_fst && (wi != '0);
  assign wr_idx         = resync ? '0 : wi;
  assign wr_last        = (wr_idx == IW'(N_IN - 1));

  // Fill index, write bank and resync pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wi      <= '0;
      wb      <= 1'b0;
      fst_err <= 1'b0;
    end else begin
      fst_err <= fill_acc && resync;
      if (fill_acc) begin
        if (wr_last) begin
          wi <= '0;
          wb <= ~wb;
        end else begin
          wi <= wr_idx + IW'(1);
        end
      end
    end
  end

  // ------------------------------------------------------------- drain side
  logic [IW-1:0] j;
  logic [PW-1:0] p;
  logic          op_hs, j_last, p_last, drain_done;

  assign op_vld     = full[rb];
  assign op_hs      = op_vld && op_rdy;
  assign j_last     = (j == IW'(N_IN - 1));
  assign p_last     = (p == PW'(P - 1));
  assign drain_done = op_hs && j_last && p_last;

  // Word/pass counters walk p-major; the final handshake frees the bank.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      j  <= '0;
      p  <= '0;
      rb <= 1'b0;
    end else if (op_hs) begin
      if (j_last) begin
        j <= '0;
        if (p_last) begin
          p  <= '0;
          rb <= ~rb;
        end else begin
          p <= p + PW'(1);
        end
      end else begin
        j <= j + IW'(1);
      end
    end
  end

  // --------------------------------------------------------------- banks
  for (genvar b = 0; b < 2; b++) begin : g_bank
    logic wsel, rsel;
    assign wsel = fill_acc && (wb == 1'(b));
    assign rsel = rb == 1'(b);

    full_stage_seq_bank #(
      .N_IN (N_IN),
      .DW   (DW),
      .IW   (IW)
    ) u_bank (
      .clk      (clk),
      .reset    (reset),
      .wr_en    (wsel),
      .wr_idx   (wr_idx),
      .wr_data  (stage_data),
      .mode_we  (wsel && (wr_idx == '0)),
      .mode_in  (mode),
      .set_full (wsel && wr_last),
      .clr_full (drain_done && rsel),
      .rd_idx   (j),
      .rd_data  (rd_data[b]),
      .full     (full[b]),
      .mode     (bmode[b])
    );
  end

  // Operand outputs; forced to zero whenever no vector is draining.
  always_comb begin
    op_data     = '0;
    op_tap_addr = '0;
    op_first    = 1'b0;
    op_last     = 1'b0;
    op_mode     = 1'b0;
    if (op_vld) begin
      op_data  = rd_data[rb];
      op_mode  = bmode[rb];
      op_first = (j == '0);
      op_last  = j_last;
      // Forward walks tap rows p*N_IN+j; error mode walks columns j*P+p.
      op_tap_addr = bmode[rb] ? RW'(int'(j) * P + int'(p))
                              : RW'(int'(p) * N_IN + int'(j));
    end
  end

endmodule

// File: tb/tb_full_stage_seq.sv
`timescale 1ns/1ps
module tb_full_stage_seq;
  localparam int N_IN = 8, N_OUT = 6, LANES = 2, DW = 32;
  localparam int P = 3, NT = 48, TW = 6, RW = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] tap_in;
  logic          tap_in_vld, tap_in_rdy, tap_wr_en, load_finish;
  logic [TW-1:0] tap_wr_addr;
  logic [DW-1:0] tap_wr_data;
  logic [DW-1:0] stage_data;
  logic          stage_data_vld, stage_data_fst, stage_data_rdy, mode;
  logic [DW-1:0] op_data;
  logic [RW-1:0] op_tap_addr;
  logic          op_vld, op_rdy, op_first, op_last, op_mode, fst_err;

  full_stage_seq #(.N_IN(N_IN), .N_OUT(N_OUT), .LANES(LANES), .DW(DW)) dut (
    .clk(clk), .reset(reset),
    .tap_in(tap_in), .tap_in_vld(tap_in_vld), .tap_in_rdy(tap_in_rdy),
    .tap_wr_en(tap_wr_en), .tap_wr_addr(tap_wr_addr), .tap_wr_data(tap_wr_data),
    .load_finish(load_finish),
    .stage_data(stage_data), .stage_data_vld(stage_data_vld),
    .stage_data_fst(stage_data_fst), .stage_data_rdy(stage_data_rdy), .mode(mode),
    .op_data(op_data), .op_tap_addr(op_tap_addr), .op_vld(op_vld), .op_rdy(op_rdy),
    .op_first(op_first), .op_last(op_last), .op_mode(op_mode), .fst_err(fst_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [RW-1:0] addr;
    logic          first, last, mode, vend;
  } op_t;
  typedef struct packed {
    logic [TW-1:0] a;
    logic [DW-1:0] d;
  } tap_t;

  op_t  opq[$];
  tap_t tapq[$];
  int   vend_q[$];
  int   n_chk = 0, n_err = 0, n_ops = 0, n_fst_err = 0, exp_fst = 0, cyc = 0;
  int   first_rdy_cyc, done_cyc, fst_cyc;
  logic rdy_tog = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // op_rdy: steady 1, or toggling every cycle
  initial begin
    op_rdy = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      op_rdy = rdy_tog ? ~op_rdy : 1'b1;
    end
  end

  // operand scoreboard
  initial begin
    op_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        chk("no_x", 64'($isunknown({fst_err, tap_wr_en, op_vld})), 64'd0);
        if (fst_err) n_fst_err++;
        if (op_vld && op_rdy) begin
          if (opq.size() == 0) chk("op_unexpected", 64'd1, 64'd0);
          else begin
            e = opq.pop_front();
            chk("op_data",  64'(op_data),     64'(e.data));
            chk("op_addr",  64'(op_tap_addr), 64'(e.addr));
            chk("op_first", 64'(op_first),    64'(e.first));
            chk("op_last",  64'(op_last),     64'(e.last));
            chk("op_mode",  64'(op_mode),     64'(e.mode));
            n_ops++;
            if (e.vend) vend_q.push_back(cyc);
          end
        end
      end
    end
  end

  // tap write scoreboard
  initial begin
    tap_t t;
    forever begin
      @(negedge clk);
      if (!reset && tap_wr_en) begin
        if (tapq.size() == 0) chk("tap_unexpected", 64'd1, 64'd0);
        else begin
          t = tapq.pop_front();
          chk("tap_addr", 64'(tap_wr_addr), 64'(t.a));
          chk("tap_data", 64'(tap_wr_data), 64'(t.d));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic push_ops(input logic [DW-1:0] v [N_IN], input logic m);
    op_t e;
    for (int pp = 0; pp < P; pp++)
      for (int jj = 0; jj < N_IN; jj++) begin
        e.data  = v[jj];
        e.addr  = m ? RW'(jj * P + pp) : RW'(pp * N_IN + jj);
        e.first = (jj == 0);
        e.last  = (jj == N_IN - 1);
        e.mode  = m;
        e.vend  = (pp == P - 1) && (jj == N_IN - 1);
        opq.push_back(e);
      end
  endtask

  task automatic load_taps(input logic [DW-1:0] base, input int cnt);
    tap_t t;
    for (int kk = 0; kk < cnt; kk++) begin
      tap_in     = base + DW'(kk);
      tap_in_vld = 1'b1;
      t.a = TW'(kk);
      t.d = tap_in;
      tapq.push_back(t);
      if (kk == NT - 1) begin
        @(negedge clk);
        chk("ld_fin_early", 64'(load_finish), 64'd0);
      end
      @(posedge clk);
      #1;
    end
    tap_in_vld = 1'b0;
  endtask

  // Words base+n; fst on word 0 and on word fst_at. mode driven to the
  // opposite value on words that must not be sampled.
  task automatic send_vec(input logic [DW-1:0] base, input logic m, input int nw, input int fst_at);
    logic [DW-1:0] vec [N_IN];
    int   idx = 0, t, ac;
    logic f, vm = 1'b0;
    for (int n = 0; n < nw; n++) begin
      f = (n == 0) || (n == fst_at);
      stage_data     = base + DW'(n);
      stage_data_fst = f;
      stage_data_vld = 1'b1;
      mode           = (f || idx == 0) ? m : ~m;
      t = 0;
      forever begin
        @(negedge clk);
        if (stage_data_rdy) break;
        t++;
        if (t > 400) break;
      end
      if (!stage_data_rdy) begin
        chk("fill_timeout", 64'd0, 64'd1);
        stage_data_vld = 1'b0;
        return;
      end
      ac = cyc;
      if (n == 0) first_rdy_cyc = ac;
      @(posedge clk);
      if (f && idx != 0) begin
        idx = 0;
        exp_fst++;
        fst_cyc = ac;
      end
      vec[idx] = stage_data;
      if (idx == 0) vm = mode;
      idx++;
      if (idx == N_IN) begin
        push_ops(vec, vm);
        idx = 0;
        done_cyc = ac;
      end
      #1;
    end
    stage_data_vld = 1'b0;
    stage_data_fst = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int t = 0;
    while ((opq.size() != 0 || op_vld) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk(tag, 64'(opq.size() == 0 && !op_vld), 64'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int b0, vb, b_done, c_rdy, t;
    reset = 1'b1;
    tap_in = '0; tap_in_vld = 1'b0;
    stage_data = '0; stage_data_vld = 1'b0; stage_data_fst = 1'b0; mode = 1'b0;
    #3;
    chk("rst_load_finish", 64'(load_finish),    64'd0);
    chk("rst_stage_rdy",   64'(stage_data_rdy), 64'd0);
    chk("rst_op_vld",      64'(op_vld),         64'd0);
    chk("rst_op_first",    64'(op_first),       64'd0);
    chk("rst_op_last",     64'(op_last),        64'd0);
    chk("rst_op_mode",     64'(op_mode),        64'd0);
    chk("rst_fst_err",     64'(fst_err),        64'd0);
    chk("rst_tap_wr_en",   64'(tap_wr_en),      64'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("tap_rdy_out_rst", 64'(tap_in_rdy), 64'd1);

    // partial load, reset, then the real load must restart at k=0
    load_taps(32'd500, 20);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midload_rst_fin", 64'(load_finish), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    load_taps(32'd0, NT);
    chk("load_finish",  64'(load_finish), 64'd1);
    chk("tap_rdy_done", 64'(tap_in_rdy),  64'd0);
    tap_in = 32'd99;
    tap_in_vld = 1'b1;
    @(negedge clk);
    chk("tap_wr_after", 64'(tap_wr_en), 64'd0);
    chk("tapq_drained", 64'(tapq.size()), 64'd0);
    @(posedge clk);
    #1;
    tap_in_vld = 1'b0;

    // forward mode, latency one cycle after the last word
    b0 = n_ops;
    send_vec(32'd100, 1'b0, N_IN, -1);
    @(negedge clk);
    chk("lat_op_vld",   64'(op_vld),   64'd1);
    chk("lat_op_first", 64'(op_first), 64'd1);
    wait_drain("drain_m0");
    chk("nops_m0", 64'(n_ops - b0), 64'd24);

    // error (transposed) mode
    b0 = n_ops;
    send_vec(32'd100, 1'b1, N_IN, -1);
    wait_drain("drain_m1");
    chk("nops_m1", 64'(n_ops - b0), 64'd24);

    // back-to-back with toggling op_rdy; third vector stalls
    rdy_tog = 1'b1;
    vb = vend_q.size();
    b0 = n_ops;
    send_vec(32'h200, 1'b0, N_IN, -1);
    send_vec(32'h300, 1'b1, N_IN, -1);
    b_done = done_cyc;
    send_vec(32'h400, 1'b0, N_IN, -1);
    c_rdy = first_rdy_cyc;
    wait_drain("drain_b2b");
    rdy_tog = 1'b0;
    chk("nops_b2b", 64'(n_ops - b0), 64'd72);
    if (vend_q.size() > vb) begin
      chk("b_fill_overlap", 64'(b_done < vend_q[vb]), 64'd1);
      chk("c_rdy_after_a",  64'(c_rdy), 64'(vend_q[vb] + 1));
    end else chk("a_vend_seen", 64'd0, 64'd1);

    // fst on the 4th word resyncs the vector
    b0 = n_ops;
    send_vec(32'h500, 1'b1, 11, 3);
    wait_drain("drain_fst");
    chk("fst_err_cycles", 64'(n_fst_err), 64'd1);
    chk("fst_err_model",  64'(n_fst_err), 64'(exp_fst));
    chk("fst_done_gap",   64'(done_cyc - fst_cyc), 64'd7);
    chk("nops_fst",       64'(n_ops - b0), 64'd24);

    // reset while operand 10 is presented
    b0 = n_ops;
    send_vec(32'h600, 1'b0, N_IN, -1);
    t = 0;
    while (n_ops - b0 < 10 && t < 200) begin
      @(posedge clk);
      t++;
    end
    chk("reach_op10", 64'(n_ops - b0), 64'd10);
    #2;
    reset = 1'b1;
    #1;
    chk("mr_op_vld",      64'(op_vld),         64'd0);
    chk("mr_op_first",    64'(op_first),       64'd0);
    chk("mr_op_last",     64'(op_last),        64'd0);
    chk("mr_op_mode",     64'(op_mode),        64'd0);
    chk("mr_op_data",     64'(op_data),        64'd0);
    chk("mr_op_addr",     64'(op_tap_addr),    64'd0);
    chk("mr_fst_err",     64'(fst_err),        64'd0);
    chk("mr_tap_wr_en",   64'(tap_wr_en),      64'd0);
    chk("mr_load_finish", 64'(load_finish),    64'd0);
    chk("mr_stage_rdy",   64'(stage_data_rdy), 64'd0);
    opq.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("mr_tap_rdy", 64'(tap_in_rdy), 64'd1);
    stage_data_vld = 1'b1;
    stage_data = 32'h777;
    repeat (3) begin
      @(negedge clk);
      chk("rdy_before_reload", 64'(stage_data_rdy), 64'd0);
    end
    @(posedge clk);
    #1;
    stage_data_vld = 1'b0;
    load_taps(32'd0, NT);
    chk("reload_finish", 64'(load_finish), 64'd1);
    send_vec(32'h700, 1'b1, N_IN, -1);
    wait_drain("drain_post_rst");

    chk("opq_empty",  64'(opq.size()),  64'd0);
    chk("tapq_empty", 64'(tapq.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
